// File: rtl/counting_fsm.sv
// rtl/counting_fsm.sv - Moore detector for the symbol pattern 1+ 2+ 3+ with optional match counter
//
// Purpose:
//   Samples one 2-bit symbol per rising clock edge. ans is high while the
//   accepted history ends in one or more 1s, then one or more 2s, then one
//   or more 3s. Symbol 0 is a break and returns the detector to IDLE.
//
// Optional feature macro: COUNTING_MATCH_CNT_EN
//   defined   : match_cnt counts TWO->THREE entries and saturates at 2^CNT_W-1
//   undefined : match_cnt is tied to 0 and no counter flops exist
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   num        in   2      symbol sampled every rising edge (0 = break)
//   ans        out  1      high while the state is THREE
//   match_cnt  out  CNT_W  saturating count of completed patterns

module counting_fsm #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       num,
   output logic             ans,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2,
      THREE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A 1 always restarts the pattern; any symbol that does not extend the
   // current run (or advance to the next run) falls back to IDLE.
   always_comb begin
      state_next = IDLE;
      case (num)
         2'd1: state_next = ONE;
         2'd2: begin
            if ((state == ONE) || (state == TWO)) begin
               state_next = TWO;
            end
         end
         2'd3: begin
            if ((state == TWO) || (state == THREE)) begin
               state_next = THREE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign ans = (state == THREE);

`ifdef COUNTING_MATCH_CNT_EN
   logic enter_three;

   // Only the TWO->THREE entry counts; lingering in THREE does not.
   assign enter_three = (state == TWO) && (state_next == THREE);

   always_ff @(posedge clk) begin
      if (reset) begin
         match_cnt <= '0;
      end else if (enter_three && (match_cnt != {CNT_W{1'b1}})) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_counting_fsm.sv
// tb/tb_counting_fsm.sv - directed self-checking bench for counting_fsm

module tb_counting_fsm;

`ifdef COUNTING_MATCH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] num;
   logic       ans;
   logic [7:0] match_cnt;
   logic       ans_s;
   logic [1:0] match_cnt_s;

   int checks = 0;
   int errors = 0;

   counting_fsm #(.CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .num       (num),
      .ans       (ans),
      .match_cnt (match_cnt)
   );

   counting_fsm #(.CNT_W(2)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .num       (num),
      .ans       (ans_s),
      .match_cnt (match_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [1:0] s);
      num = s;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      num   = 2'd3;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (ans !== 1'b0) begin
         errors++;
         $display("FAIL reset_ans: got %b expected 0", ans);
      end
      checks++;
      if (match_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d expected 0", match_cnt);
      end
      checks++;
      if (match_cnt_s !== 2'd0) begin
         errors++;
         $display("FAIL reset_cnt_sat: got %0d expected 0", match_cnt_s);
      end
   endtask

   task automatic test_canonical();
      logic [1:0] seq [17] = '{1,1,2,3,3,1,2,1,1,1,2,2,2,3,3,3,1};
      logic       exp [17] = '{0,0,0,1,1,0,0,0,0,0,0,0,0,1,1,1,0};
      logic [7:0] exp_cnt;
      pulse_reset();
      for (int i = 0; i < 17; i++) begin
         drive(seq[i]);
         checks++;
         if (ans !== exp[i]) begin
            errors++;
            $display("FAIL canonical_ans[%0d]: got %b expected %b", i, ans, exp[i]);
         end
      end
      exp_cnt = CNT_EN ? 8'd2 : 8'd0;
      checks++;
      if (match_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL canonical_cnt: got %0d expected %0d", match_cnt, exp_cnt);
      end
   endtask

   task automatic test_breaks();
      logic [1:0] s0 [4] = '{1,2,0,3};
      logic       e0 [4] = '{0,0,0,0};
      logic [1:0] s1 [2] = '{1,3};
      logic [1:0] s2 [2] = '{2,3};
      logic [1:0] s3 [4] = '{1,2,3,2};
      logic       e3 [4] = '{0,0,1,0};
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         drive(s0[i]);
         checks++;
         if (ans !== e0[i]) begin
            errors++;
            $display("FAIL break_zero[%0d]: got %b expected %b", i, ans, e0[i]);
         end
      end
      pulse_reset();
      for (int i = 0; i < 2; i++) begin
         drive(s1[i]);
         checks++;
         if (ans !== 1'b0) begin
            errors++;
            $display("FAIL break_one_three[%0d]: got %b expected 0", i, ans);
         end
      end
      pulse_reset();
      for (int i = 0; i < 2; i++) begin
         drive(s2[i]);
         checks++;
         if (ans !== 1'b0) begin
            errors++;
            $display("FAIL break_idle_two_three[%0d]: got %b expected 0", i, ans);
         end
      end
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         drive(s3[i]);
         checks++;
         if (ans !== e3[i]) begin
            errors++;
            $display("FAIL break_three_two[%0d]: got %b expected %b", i, ans, e3[i]);
         end
      end
   endtask

   task automatic test_restart();
      logic [1:0] seq [6] = '{1,2,3,1,2,3};
      logic       exp [6] = '{0,0,1,0,0,1};
      logic [7:0] exp_cnt;
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         drive(seq[i]);
         checks++;
         if (ans !== exp[i]) begin
            errors++;
            $display("FAIL restart_ans[%0d]: got %b expected %b", i, ans, exp[i]);
         end
      end
      exp_cnt = CNT_EN ? 8'd2 : 8'd0;
      checks++;
      if (match_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL restart_cnt: got %0d expected %0d", match_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_cnt;
      pulse_reset();
      drive(2'd1);
      drive(2'd2);
      num   = 2'd3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (ans !== 1'b0) begin
         errors++;
         $display("FAIL midreset_during: got %b expected 0", ans);
      end
      drive(2'd3);
      checks++;
      if (ans !== 1'b0) begin
         errors++;
         $display("FAIL midreset_three: got %b expected 0", ans);
      end
      drive(2'd1);
      drive(2'd2);
      drive(2'd3);
      checks++;
      if (ans !== 1'b1) begin
         errors++;
         $display("FAIL midreset_recover: got %b expected 1", ans);
      end
      exp_cnt = CNT_EN ? 8'd1 : 8'd0;
      checks++;
      if (match_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL midreset_cnt: got %0d expected %0d", match_cnt, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_s;
      logic [7:0] exp_w;
      pulse_reset();
      for (int k = 1; k <= 5; k++) begin
         drive(2'd1);
         drive(2'd2);
         drive(2'd3);
         exp_s = CNT_EN ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
         exp_w = CNT_EN ? 8'(k) : 8'd0;
         checks++;
         if (match_cnt_s !== exp_s) begin
            errors++;
            $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", k, match_cnt_s, exp_s);
         end
         checks++;
         if (match_cnt !== exp_w) begin
            errors++;
            $display("FAIL sat_cnt8[%0d]: got %0d expected %0d", k, match_cnt, exp_w);
         end
         checks++;
         if (ans_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_ans[%0d]: got %b expected 1", k, ans_s);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      num   = 2'd0;
      test_reset();
      test_canonical();
      test_breaks();
      test_restart();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counting_fsm.md
Name: counting_fsm

Overview:
- Moore sequence detector for a stream of 2-bit symbols, sampled one symbol per rising clock edge.
- Output `ans` is high while the accepted history ends in the pattern 1+ 2+ 3+: one or more 1s, then one or more 2s, then one or more 3s, with no other symbol in between.
- Used as a small pattern-checker front-end; the optional match counter feeds status logic.

Parameters:
- CNT_W, 8, width of the saturating match counter (match_cnt); legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- reset  input  1  synchronous active-high reset.
- num  input  2  symbol sampled on every rising edge; legal symbols 1, 2, 3; 0 is the "break" symbol.
- ans  output  1  1 when the current state is THREE.
- match_cnt  output  CNT_W  number of completed patterns (TWO->THREE entries), saturating.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high, named reset.
- State register, encoded: IDLE=0, ONE=1, TWO=2, THREE=3. All flops update on the rising edge of clk only.
- Reset: when reset=1 at a rising edge, state<=IDLE and match_cnt<=0, so ans=0 from the next cycle. Reset overrides num. Reset mid-pattern discards all progress.
- Transitions, evaluated every edge when reset=0:
  - num=1: any state -> ONE. A 1 always (re)starts a pattern, including from THREE and TWO.
  - num=2: ONE->TWO; TWO->TWO; IDLE->IDLE; THREE->IDLE.
  - num=3: TWO->THREE; THREE->THREE; IDLE->IDLE; ONE->IDLE.
  - num=0: any state -> IDLE.
- ans = (state==THREE). Moore output, combinational decode of the registered state, glitch-free. Latency: the first 3 of a valid pattern raises ans after the same edge that samples it; ans stays high for each further consecutive 3.
- match_cnt:
  - Increments by 1 on each TWO->THREE transition.
  - Staying in THREE does not increment it.
  - It saturates at 2^CNT_W-1; no wrap-around.
- No handshake; num is assumed stable around the rising edge. No X-propagation handling is required beyond reset.

Optional Feature:
- Macro COUNTING_MATCH_CNT_EN.
- Defined: match_cnt logic is built as described above.
- Undefined:
  - match_cnt is tied to constant 0 and no counter flops are synthesized.
  - The port list is unchanged.
  - The FSM and ans behaviour are identical in both cases.

Test Plan:
- Reset: assert reset for 2 edges with num=3 -> ans=0 and match_cnt=0 afterwards.
- Canonical stream 1 1 2 3 3 1 2 1 1 1 2 2 2 3 3 3 1, one symbol per edge, with reset=0 throughout:
  - ans after each edge: 0 0 0 1 1 0 0 0 0 0 0 0 0 1 1 1 0.
  - match_cnt ends at 2 with COUNTING_MATCH_CNT_EN defined, and 0 without it.
- Breaks:
  - 1 2 0 3 -> ans stays 0.
  - 1 3 -> ans 0.
  - 2 3 starting from IDLE -> ans 0.
  - 1 2 3 2 -> ans goes 1 then 0 (THREE->IDLE on 2).
- Restart: 1 2 3 1 2 3 -> ans pattern 0 0 1 0 0 1, with match_cnt=2.
- Reset mid-pattern: 1 2, then reset for one edge, then 3 -> ans remains 0; a following 1 2 3 gives ans=1 on the 3.
- Saturation with CNT_W=2: repeat 1 2 3 five times -> match_cnt reaches 3 and holds at 3.
